sio_dmu_pkt_chk: RTL and testbench
==================================

Name: sio_dmu_pkt_chk

Overview:
- Synthesizable, parametrised checker for the SIU->DMU outbound response path.
- Tracks header and payload beats on NUM_CH independent lanes.
- Per packet: captures response type and tag, checks per-16-bit parity on every payload beat, counts beats, flags protocol violations.
- Sits beside the SIO outbound datapath on iol2clk. Drives sticky error flags and per-packet completion strobes to the DMU-side scoreboard and error logger.

Parameters:
- DATA_W, 128, payload/header bus width per lane; multiple of 16, at least 128.
- BEATS, 4, payload beats per data-carrying packet; range 1..16.
- NUM_CH, 1, number of independent lanes.
- PAR_ODD, 0, 0 = even parity per 16-bit slice, 1 = odd.
- Derived (localparam, not overridable): PAR_W = DATA_W/16.

Ports:
- iol2clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- hdr_vld  in  NUM_CH  header cycle valid, one bit per lane.
- datareq  in  NUM_CH  sampled with hdr_vld; 1 = payload follows.
- data  in  NUM_CH*DATA_W  lane-concatenated data; lane 0 in the LSBs.
- parity  in  NUM_CH*PAR_W  lane-concatenated parity.
- err_clr  in  1  clears all sticky error bits.
- pkt_done  out  NUM_CH  one-cycle completion strobe.
- pkt_has_data  out  NUM_CH  valid with pkt_done; 1 = packet carried payload.
- rsp_type  out  NUM_CH*6  data[DATA_W-1 -: 6] captured at header.
- rsp_tag  out  NUM_CH*16  data[79:64] captured at header.
- err_par  out  NUM_CH  sticky: parity mismatch on any payload beat.
- err_ovl  out  NUM_CH  sticky: header arrived during payload.
- err_orph  out  NUM_CH  sticky: datareq without hdr_vld.
- pkt_cnt  out  NUM_CH*32  completed packets (feature-dependent).
- beat_cnt  out  NUM_CH*32  payload beats seen (feature-dependent).

Behaviour:
- Reset: every output is 0, every lane FSM is IDLE, beat counter is 0.
- Reset mid-packet: the packet is abandoned with no pkt_done.
- Each lane runs a two-state FSM: IDLE, PAY, with a beat counter of clog2(BEATS+1) bits.
- IDLE with hdr_vld=1:
  - rsp_type and rsp_tag are registered and hold until the next accepted header.
  - If datareq=1: go to PAY with counter=0. The first payload beat is the cycle after the header.
  - If datareq=0: pkt_done=1 and pkt_has_data=0 in the next cycle.
- PAY: every cycle is a payload beat; no gaps are allowed.
  - Parity is computed per slice i as ^data[16i+15:16i], XOR PAR_ODD, and compared with parity[i]. Any mismatch sets err_par.
  - The counter increments each beat. On beat BEATS-1, return to IDLE and drive pkt_done=1, pkt_has_data=1 the next cycle.
- hdr_vld=1 in PAY:
  - Sets err_ovl.
  - The current packet is aborted with no pkt_done.
  - The new header is accepted as if in IDLE, in the same cycle.
- datareq=1 with hdr_vld=0 in any state sets err_orph. It does not change state.
- Sticky error behaviour:
  - Error bits are registered, so they rise one cycle after the offending cycle.
  - err_clr=1 clears them. If err_clr and a new error occur in the same cycle, set wins.
- Header in the same cycle as pkt_done: legal; back-to-back packets with no idle cycle are supported.
- Lanes are fully independent. err_clr is shared across lanes.

Optional Feature:
- Macro: SIO_DMU_PKT_CHK_STATS_EN.
- Defined:
  - pkt_cnt increments on each pkt_done.
  - beat_cnt increments on each payload beat.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF; they do not wrap.
  - Both are cleared only by rst.
- Undefined: pkt_cnt and beat_cnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Package sio_dmu_pkt_pkg holds:
  - FSM state enum {IDLE, PAY};
  - field constants RSP_TYPE_W=6, RSP_TAG_W=16, RSP_TAG_LSB=64, PAR_SLICE_W=16;
  - the parity-function macro/function.
- Sub-module sio_dmu_pkt_lane implements one lane: FSM, capture, parity check, sticky errors, optional counters.
- The top module generates NUM_CH instances and handles only port slicing.

Test Plan:
- Single 4-beat packet: hdr_vld=1, datareq=1, data[127:122]=6'h2A, data[79:64]=16'h1234, followed by 4 beats with correct even parity -> pkt_done=1 and pkt_has_data=1 one cycle after beat 4; rsp_type=6'h2A, rsp_tag=16'h1234; no errors.
- No-payload header: hdr_vld=1, datareq=0 -> pkt_done=1 next cycle with pkt_has_data=0.
- Parity fault: beat 3 with parity[0] flipped -> err_par=1 one cycle later and held; pkt_done still occurs; err_clr pulse -> err_par=0.
- Overlap: new header with tag 16'h0055 on beat 2 of the current packet -> err_ovl=1; no pkt_done for the old packet; new packet completes with rsp_tag=16'h0055.
- Back-to-back packets plus a reset during beat 2 of the third packet -> 2 pkt_done strobes, then all outputs 0; with SIO_DMU_PKT_CHK_STATS_EN, pkt_cnt=2 and beat_cnt=9 before reset.
- NUM_CH=2, DATA_W=256, BEATS=2: orphan datareq on lane 1 while lane 0 runs a packet -> err_orph=2'b10; lane 0 completes cleanly.

Source files
------------

// File: rtl/sio_dmu_pkt_pkg.sv
// Shared types, field positions and parity helper for the SIU->DMU outbound packet checker.
package sio_dmu_pkt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PAY  = 1'b1
  } lane_state_e;

  localparam int RSP_TYPE_W  = 6;
  localparam int RSP_TAG_W   = 16;
  localparam int RSP_TAG_LSB = 64;
  localparam int PAR_SLICE_W = 16;

  // Expected parity bit for one 16-bit slice; odd=1 selects odd parity.
  function automatic logic slice_par(input logic [PAR_SLICE_W-1:0] s, input logic odd);
    return (^s) ^ odd;
  endfunction

endpackage

// File: rtl/sio_dmu_pkt_chk_lane.sv
// One checker lane: header/payload FSM, response capture, slice parity check, sticky errors.
// Packet/beat statistics counters exist only when SIO_DMU_PKT_CHK_STATS_EN is defined.
module sio_dmu_pkt_lane
  import sio_dmu_pkt_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int BEATS   = 4,
  parameter int PAR_ODD = 0
) (
  input  logic                    iol2clk,
  input  logic                    rst,
  input  logic                    hdr_vld,
  input  logic                    datareq,
  input  logic [DATA_W-1:0]       data,
  input  logic [DATA_W/16-1:0]    parity,
  input  logic                    err_clr,
  output logic                    pkt_done,
  output logic                    pkt_has_data,
  output logic [RSP_TYPE_W-1:0]   rsp_type,
  output logic [RSP_TAG_W-1:0]    rsp_tag,
  output logic                    err_par,
  output logic                    err_ovl,
  output logic                    err_orph,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             beat_cnt
);

  localparam int   PAR_W = DATA_W / PAR_SLICE_W;
  localparam int   CNT_W = $clog2(BEATS + 1);
  localparam logic ODD   = (PAR_ODD != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  lane_state_e      state;
  logic [CNT_W-1:0] cnt;

  logic [PAR_W-1:0] par_mis;
  logic             beat;
  logic             last_beat;
  logic             done_set;
  logic             par_set;
  logic             ovl_set;
  logic             orph_set;

  always_comb begin
    par_mis = '0;
    for (int i = 0; i < PAR_W; i++) begin
      par_mis[i] = slice_par(data[i*PAR_SLICE_W +: PAR_SLICE_W], ODD) ^ parity[i];
    end
  end

  // A header cycle in PAY is never a payload beat: it aborts the packet instead.
  assign beat      = (state == PAY) && !hdr_vld;
  assign last_beat = beat && (cnt == LAST_CNT);
  assign done_set  = last_beat || (hdr_vld && !datareq);
  assign par_set   = beat && (|par_mis);
  assign ovl_set   = (state == PAY) && hdr_vld;
  assign orph_set  = datareq && !hdr_vld;

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pkt_done     <= 1'b0;
      pkt_has_data <= 1'b0;
    end else begin
      pkt_done     <= done_set;
      pkt_has_data <= last_beat;
      if (hdr_vld) begin
        state <= datareq ? PAY : IDLE;
        cnt   <= '0;
      end else if (last_beat) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      rsp_type <= '0;
      rsp_tag  <= '0;
    end else if (hdr_vld) begin
      rsp_type <= data[DATA_W-1 -: RSP_TYPE_W];
      rsp_tag  <= data[RSP_TAG_LSB +: RSP_TAG_W];
    end
  end

  // Sticky flags: a new error in the clear cycle survives the clear.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      err_par  <= 1'b0;
      err_ovl  <= 1'b0;
      err_orph <= 1'b0;
    end else begin
      err_par  <= (err_par  && !err_clr) || par_set;
      err_ovl  <= (err_ovl  && !err_clr) || ovl_set;
      err_orph <= (err_orph && !err_clr) || orph_set;
    end
  end

`ifdef SIO_DMU_PKT_CHK_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (done_set && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (beat && (beat_cnt_q != 32'hFFFF_FFFF)) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`else
  assign pkt_cnt  = '0;
  assign beat_cnt = '0;
`endif

endmodule

// File: rtl/sio_dmu_pkt_chk.sv
// SIU->DMU outbound response checker top: NUM_CH independent lanes, port slicing only.
// Optional statistics counters are enabled with SIO_DMU_PKT_CHK_STATS_EN.
module sio_dmu_pkt_chk
  import sio_dmu_pkt_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int BEATS   = 4,
  parameter int NUM_CH  = 1,
  parameter int PAR_ODD = 0
) (
  input  logic                           iol2clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              hdr_vld,
  input  logic [NUM_CH-1:0]              datareq,
  input  logic [NUM_CH*DATA_W-1:0]       data,
  input  logic [NUM_CH*(DATA_W/16)-1:0]  parity,
  input  logic                           err_clr,
  output logic [NUM_CH-1:0]              pkt_done,
  output logic [NUM_CH-1:0]              pkt_has_data,
  output logic [NUM_CH*RSP_TYPE_W-1:0]   rsp_type,
  output logic [NUM_CH*RSP_TAG_W-1:0]    rsp_tag,
  output logic [NUM_CH-1:0]              err_par,
  output logic [NUM_CH-1:0]              err_ovl,
  output logic [NUM_CH-1:0]              err_orph,
  output logic [NUM_CH*32-1:0]           pkt_cnt,
  output logic [NUM_CH*32-1:0]           beat_cnt
);

  localparam int PAR_W = DATA_W / 16;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    sio_dmu_pkt_lane #(
      .DATA_W  (DATA_W),
      .BEATS   (BEATS),
      .PAR_ODD (PAR_ODD)
    ) u_lane (
      .iol2clk      (iol2clk),
      .rst          (rst),
      .hdr_vld      (hdr_vld[g]),
      .datareq      (datareq[g]),
      .data         (data[g*DATA_W +: DATA_W]),
      .parity       (parity[g*PAR_W +: PAR_W]),
      .err_clr      (err_clr),
      .pkt_done     (pkt_done[g]),
      .pkt_has_data (pkt_has_data[g]),
      .rsp_type     (rsp_type[g*RSP_TYPE_W +: RSP_TYPE_W]),
      .rsp_tag      (rsp_tag[g*RSP_TAG_W +: RSP_TAG_W]),
      .err_par      (err_par[g]),
      .err_ovl      (err_ovl[g]),
      .err_orph     (err_orph[g]),
      .pkt_cnt      (pkt_cnt[g*32 +: 32]),
      .beat_cnt     (beat_cnt[g*32 +: 32])
    );
  end

endmodule

// File: tb/tb_sio_dmu_pkt_chk.sv
// Scoreboard bench for sio_dmu_pkt_chk: default 1-lane build plus a 2-lane 256-bit 2-beat build.
module tb_sio_dmu_pkt_chk;

  logic iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  logic rst;
  logic err_clr;

  logic         hdr_vld0, datareq0;
  logic [127:0] data0;
  logic [7:0]   parity0;
  logic         done0, has0, ep0, eo0, eor0;
  logic [5:0]   type0;
  logic [15:0]  tag0;
  logic [31:0]  pc0, bc0;

  logic [1:0]   hdr_vld1, datareq1;
  logic [511:0] data1;
  logic [31:0]  parity1;
  logic [1:0]   done1, has1, ep1, eo1, eor1;
  logic [11:0]  type1;
  logic [31:0]  tag1;
  logic [63:0]  pc1, bc1;

  sio_dmu_pkt_chk dut0 (
    .iol2clk(iol2clk), .rst(rst), .hdr_vld(hdr_vld0), .datareq(datareq0),
    .data(data0), .parity(parity0), .err_clr(err_clr),
    .pkt_done(done0), .pkt_has_data(has0), .rsp_type(type0), .rsp_tag(tag0),
    .err_par(ep0), .err_ovl(eo0), .err_orph(eor0), .pkt_cnt(pc0), .beat_cnt(bc0)
  );

  sio_dmu_pkt_chk #(.DATA_W(256), .BEATS(2), .NUM_CH(2), .PAR_ODD(0)) dut1 (
    .iol2clk(iol2clk), .rst(rst), .hdr_vld(hdr_vld1), .datareq(datareq1),
    .data(data1), .parity(parity1), .err_clr(err_clr),
    .pkt_done(done1), .pkt_has_data(has1), .rsp_type(type1), .rsp_tag(tag1),
    .err_par(ep1), .err_ovl(eo1), .err_orph(eor1), .pkt_cnt(pc1), .beat_cnt(bc1)
  );

  typedef struct packed {
    logic        has;
    logic [5:0]  typ;
    logic [15:0] tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   seen0  = 0;
  int   seen1  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every completion strobe is matched against the next expected packet.
  always @(negedge iol2clk) begin
    if (done0 === 1'b1) begin
      seen0++;
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 64'(done0), 64'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_has_data", 64'(has0), 64'(e0.has));
        chk("dut0_rsp_type", 64'(type0), 64'(e0.typ));
        chk("dut0_rsp_tag", 64'(tag0), 64'(e0.tag));
      end
    end
    if (done1[0] === 1'b1) begin
      seen1++;
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 64'(done1[0]), 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_has_data", 64'(has1[0]), 64'(e1.has));
        chk("dut1_rsp_type", 64'(type1[5:0]), 64'(e1.typ));
        chk("dut1_rsp_tag", 64'(tag1[15:0]), 64'(e1.tag));
      end
    end
    if (done1[1] !== 1'b0) chk("dut1_lane1_done", 64'(done1[1]), 64'd0);
  end

  function automatic logic [7:0] par128(input logic [127:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^d[i*16 +: 16];
    return r;
  endfunction

  function automatic logic [15:0] par256(input logic [255:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ^d[i*16 +: 16];
    return r;
  endfunction

  task automatic cyc0(input logic hv, input logic dr, input logic [127:0] d, input logic [7:0] p);
    hdr_vld0 = hv; datareq0 = dr; data0 = d; parity0 = p;
    @(posedge iol2clk); #1;
  endtask

  task automatic hdr0(input logic [5:0] t, input logic [15:0] g, input logic dr);
    logic [127:0] d;
    d = {4{32'h5A5A_C3C3}};
    d[127:122] = t;
    d[79:64]   = g;
    cyc0(1'b1, dr, d, par128(d));
  endtask

  task automatic beat0(input logic [127:0] d, input logic [7:0] flip);
    cyc0(1'b0, 1'b0, d, par128(d) ^ flip);
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) cyc0(1'b0, 1'b0, 128'h0, 8'h0);
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    idle0(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d1;
    logic [127:0] bb;
    rst = 1'b1; err_clr = 1'b0;
    hdr_vld0 = 1'b0; datareq0 = 1'b0; data0 = '0; parity0 = '0;
    hdr_vld1 = '0; datareq1 = '0; data1 = '0; parity1 = '0;
    repeat (2) @(posedge iol2clk);
    #1 rst = 1'b0;

    chk("rst_done", 64'(done0), 0);
    chk("rst_has", 64'(has0), 0);
    chk("rst_type", 64'(type0), 0);
    chk("rst_tag", 64'(tag0), 0);
    chk("rst_errs", 64'({ep0, eo0, eor0}), 0);
    chk("rst_cnts", {pc0, bc0}, 0);
    chk("rst_dut1_done", 64'(done1), 0);

    // Single clean 4-beat packet
    bb = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    q0.push_back(exp_t'{has: 1'b1, typ: 6'h2A, tag: 16'h1234});
    hdr0(6'h2A, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) beat0(bb ^ 128'(i * 32'h1111_0103), 8'h0);
    chk("t1_no_early_done", 64'(done0), 0);
    beat0(bb ^ 128'h77, 8'h0);
    chk("t1_done_latency", 64'(done0), 1);
    idle0(1);
    chk("t1_errs", 64'({ep0, eo0, eor0}), 0);
    chk("t1_type_hold", 64'(type0), 64'h2A);
    chk("t1_tag_hold", 64'(tag0), 64'h1234);

    // Header without payload
    q0.push_back(exp_t'{has: 1'b0, typ: 6'h15, tag: 16'h00AB});
    hdr0(6'h15, 16'h00AB, 1'b0);
    chk("t2_done_next", 64'(done0), 1);
    chk("t2_has_zero", 64'(has0), 0);
    idle0(1);

    // Parity fault on beat 3
    q0.push_back(exp_t'{has: 1'b1, typ: 6'h3C, tag: 16'h4321});
    hdr0(6'h3C, 16'h4321, 1'b1);
    beat0(bb, 8'h0);
    beat0(~bb, 8'h0);
    chk("t3_par_clean", 64'(ep0), 0);
    beat0(bb ^ 128'hF0, 8'h01);
    chk("t3_par_rise", 64'(ep0), 1);
    beat0(bb, 8'h0);
    chk("t3_done_despite_par", 64'(done0), 1);
    idle0(2);
    chk("t3_par_sticky", 64'(ep0), 1);
    clr_pulse();
    chk("t3_par_cleared", 64'(ep0), 0);
    err_clr = 1'b1;
    cyc0(1'b0, 1'b1, 128'h0, 8'h0);
    err_clr = 1'b0;
    chk("t3_set_wins_clr", 64'(eor0), 1);
    clr_pulse();
    chk("t3_orph_cleared", 64'(eor0), 0);

    // Overlapping header on beat 2
    hdr0(6'h01, 16'hAAAA, 1'b1);
    beat0(bb, 8'h0);
    q0.push_back(exp_t'{has: 1'b1, typ: 6'h02, tag: 16'h0055});
    hdr0(6'h02, 16'h0055, 1'b1);
    chk("t4_ovl_set", 64'(eo0), 1);
    chk("t4_no_old_done", 64'(done0), 0);
    for (int i = 0; i < 3; i++) beat0(bb ^ 128'(i), 8'h0);
    chk("t4_no_early_done", 64'(done0), 0);
    beat0(bb, 8'h0);
    chk("t4_new_done", 64'(done0), 1);
    idle0(1);
    chk("t4_tag_hold", 64'(tag0), 64'h0055);
    chk("t4_par_clean", 64'(ep0), 0);
    clr_pulse();
    chk("t4_ovl_cleared", 64'(eo0), 0);

    // Back-to-back packets, reset mid third packet
    rst = 1'b1;
    idle0(1);
    rst = 1'b0;
    chk("t5_cnt_start", {pc0, bc0}, 0);
    q0.push_back(exp_t'{has: 1'b1, typ: 6'h11, tag: 16'h0A0A});
    hdr0(6'h11, 16'h0A0A, 1'b1);
    for (int i = 0; i < 4; i++) beat0(bb ^ 128'(i << 8), 8'h0);
    q0.push_back(exp_t'{has: 1'b1, typ: 6'h12, tag: 16'h0B0B});
    hdr0(6'h12, 16'h0B0B, 1'b1);
    for (int i = 0; i < 4; i++) beat0(~bb ^ 128'(i), 8'h0);
    hdr0(6'h13, 16'h0C0C, 1'b1);
    beat0(bb, 8'h0);
`ifdef SIO_DMU_PKT_CHK_STATS_EN
    chk("t5_pkt_cnt", 64'(pc0), 2);
    chk("t5_beat_cnt", 64'(bc0), 9);
`else
    chk("t5_pkt_cnt", 64'(pc0), 0);
    chk("t5_beat_cnt", 64'(bc0), 0);
`endif
    rst = 1'b1;
    beat0(bb, 8'h0);
    rst = 1'b0;
    chk("t5_rst_outs", {26'(0), done0, has0, type0, tag0, ep0, eo0, eor0}, 0);
    chk("t5_rst_cnts", {pc0, bc0}, 0);
    idle0(6);
    chk("t5_no_abandoned_done", 64'(seen0), 6);
    chk("t5_q0_drained", 64'(q0.size()), 0);

    // Two lanes: lane 0 packet, orphan datareq on lane 1
    d1 = {8{32'h1357_9BDF}};
    d1[255:250] = 6'h07;
    d1[79:64]   = 16'hBEEF;
    q1.push_back(exp_t'{has: 1'b1, typ: 6'h07, tag: 16'hBEEF});
    hdr_vld1 = 2'b01; datareq1 = 2'b01;
    data1 = {256'h0, d1}; parity1 = {16'h0, par256(d1)};
    @(posedge iol2clk); #1;
    hdr_vld1 = 2'b00; datareq1 = 2'b10;
    data1 = {~d1, d1 ^ 256'h1234}; parity1 = {16'h0, par256(d1 ^ 256'h1234)};
    @(posedge iol2clk); #1;
    chk("t6_orph", 64'(eor1), 64'h2);
    datareq1 = 2'b00;
    data1 = {256'h0, ~d1}; parity1 = {16'h0, par256(~d1)};
    @(posedge iol2clk); #1;
    chk("t6_lane0_done", 64'(done1), 64'h1);
    data1 = '0; parity1 = '0;
    @(posedge iol2clk); #1;
    chk("t6_par_ovl", 64'({ep1, eo1}), 0);
    chk("t6_orph_sticky", 64'(eor1), 64'h2);
    chk("t6_lane1_capture", 64'({type1[11:6], tag1[31:16]}), 0);
`ifdef SIO_DMU_PKT_CHK_STATS_EN
    chk("t6_cnts", {pc1[15:0], pc1[47:32], bc1[15:0], bc1[47:32]}, 64'h0001_0000_0002_0000);
`else
    chk("t6_cnts", {pc1[15:0], pc1[47:32], bc1[15:0], bc1[47:32]}, 0);
`endif
    chk("t6_done_count", 64'(seen1), 1);
    chk("t6_q1_drained", 64'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
